maxnet_controller: RTL and testbench
====================================

# maxnet_controller

Sequencing FSM for the 4-neuron MaxNet datapath. It runs one winner-take-all search per start request: it loads the input activations, then repeats lateral-inhibition updates until at most one neuron is still non-zero. It then reports completion, the winner and the iteration count. It sits beside the datapath in the top level, driving the datapath's `init` and `write_reg` strobes and consuming its activation status.

## Interface
- `MAX_ITER`, default 64: iteration limit used by the timeout feature; must be ≥ 1.
- `ITER_W`, default 7: width of the iteration counter; must satisfy 2^ITER_W > MAX_ITER.
- `clk` input, 1 bit: single clock; all state changes on the rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: request a new search; sampled only in IDLE.
- `active_mask` input, 4 bits: bit i = 1 when datapath neuron i activation is non-zero (registered in the datapath).
- `init` output, 1 bit: datapath load strobe (latch x1..x4 into activation registers).
- `write_reg` output, 1 bit: datapath update strobe (commit one inhibition step).
- `busy` output, 1 bit: high in every state except IDLE.
- `done` output, 1 bit: one-cycle completion pulse.
- `winner` output, 2 bits: index of the surviving neuron; valid from `done` until the next accepted `start`.
- `none_left` output, 1 bit: search ended with all activations zero (tie collapse).
- `iter_count` output, ITER_W bits: number of `write_reg` strobes issued in the current or last search.
- `timeout` output, 1 bit: last search stopped at MAX_ITER without converging.

## Operation
- States: IDLE, LOAD, EVAL, UPDATE, DONE.
- IDLE:
  - `start`=1 → LOAD.
  - On that transition, clear `iter_count`, `winner`, `none_left` and `timeout`.
- LOAD: `init`=1 for exactly one cycle → EVAL.
- EVAL: examine `active_mask`. Converged means the popcount of `active_mask` is ≤ 1.
  - Converged, exactly one bit set: `winner` ← index of that bit, `none_left` ← 0 → DONE.
  - Converged, mask = 0: `winner` ← 0, `none_left` ← 1 → DONE.
  - Not converged, timeout limit reached (see Configuration): `timeout` ← 1, `winner` ← index of the lowest set bit → DONE.
  - Otherwise → UPDATE.
- UPDATE: `write_reg`=1 for one cycle, `iter_count` increments → EVAL.
- DONE: `done`=1 for one cycle → IDLE.
- `init` and `write_reg` are never high together, and each is high only in its own state.
- `start` outside IDLE is ignored; it is not queued.
- `iter_count` saturates at 2^ITER_W−1; it never wraps.
- Reset, including mid-search:
  - State ← IDLE.
  - All outputs ← 0: `init`, `write_reg`, `busy`, `done`, `winner`=0, `none_left`, `iter_count`=0, `timeout`.
  - The datapath contents are don't-care until the next LOAD.

## Timing
- Accepted `start` is sampled at edge k:
  - LOAD during cycle k+1;
  - first EVAL during cycle k+2.
- Already-converged input: `done` high during cycle k+3, so the minimum latency is 3 cycles.
- Each non-converging EVAL adds 2 cycles (UPDATE + EVAL). With N updates, `done` is high in cycle k+3+2N.
- EVAL uses `active_mask` as registered after the preceding `init`/`write_reg` edge. The datapath must update its mask within that same edge.
- `winner`, `none_left`, `timeout` and `iter_count` are stable from the `done` cycle until the next accepted `start`.
- `start` held high continuously: a new search begins in the cycle after DONE, i.e. back-to-back searches with one IDLE cycle between them.
- `busy` rises in cycle k+1 and falls in the cycle after `done`.

## Configuration
- `MAXNET_TIMEOUT_EN` defined:
  - EVAL checks `iter_count == MAX_ITER` when not converged.
  - If equal, it sets `timeout`=1 and goes to DONE.
  - A search therefore ends in at most 3+2·MAX_ITER cycles.
- `MAXNET_TIMEOUT_EN` undefined:
  - No limit; the FSM iterates until convergence.
  - `timeout` is tied to 0.
  - `MAX_ITER` is unused.
  - `iter_count` still counts and saturates.

## Test plan
- Reset mid-UPDATE, `rst` low for 1 cycle → all outputs 0, state IDLE, and no `done` follows until a new `start`.
- `active_mask`=4'b0100 on first EVAL → `init` in k+1, `done` in k+3, `winner`=2, `iter_count`=0, no `write_reg`.
- Mask sequence 4'b1111, 4'b1011, 4'b0010 across EVALs → 2 `write_reg` pulses, `done` in k+7, `winner`=1, `iter_count`=2.
- Mask 4'b0110 then 4'b0000 → `done` with `none_left`=1, `winner`=0, `iter_count`=1.
- With `MAXNET_TIMEOUT_EN` defined and MAX_ITER=4, mask stuck at 4'b1100 → `done` in k+11, `timeout`=1, `winner`=2, `iter_count`=4.
- Same stimulus without the macro → still busy at k+50, `timeout`=0; a `start` pulse while busy has no effect.

Source files
------------

// File: rtl/maxnet_controller.sv
// Purpose : sequencing FSM for the 4-neuron MaxNet winner-take-all datapath.
// Latency : done 3 cycles after an accepted start, plus 2 cycles per inhibition update.
// Backpr. : none; start is sampled only in IDLE and is dropped, not queued, while busy.
//
// Ports   : clk, rst (async active-low); start, active_mask[3:0] in;
//           init, write_reg (datapath strobes), busy, done, winner[1:0],
//           none_left, iter_count[ITER_W-1:0], timeout out.
// Option  : define MAXNET_TIMEOUT_EN to stop a search after MAX_ITER updates
//           without convergence; otherwise timeout is tied low and MAX_ITER
//           is only range-checked.
module maxnet_controller #(
    parameter int MAX_ITER = 64,
    parameter int ITER_W   = 7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [3:0]        active_mask,
    output logic              init,
    output logic              write_reg,
    output logic              busy,
    output logic              done,
    output logic [1:0]        winner,
    output logic              none_left,
    output logic [ITER_W-1:0] iter_count,
    output logic              timeout
);

    if (MAX_ITER < 1 || (2 ** ITER_W) <= MAX_ITER) begin : g_bad_cfg
        $error("maxnet_controller: need MAX_ITER >= 1 and 2**ITER_W > MAX_ITER");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_EVAL,
        S_UPDATE,
        S_DONE
    } state_t;

    state_t      state, state_nxt;
    logic        clr_results;
    logic        res_we;
    logic        set_timeout;
    logic        converged;
    logic        limit_hit;
    logic [3:0]  mask_m1;
    logic [1:0]  low_idx;

    // Clearing the lowest set bit leaves zero iff popcount <= 1.
    assign mask_m1   = active_mask - 4'd1;
    assign converged = (active_mask & mask_m1) == 4'd0;

    // Lowest set bit; an empty mask yields 0, which is the reported winner
    // for the all-zero (tie collapse) outcome as well.
    always_comb begin
        low_idx = 2'd0;
        if (active_mask[0])      low_idx = 2'd0;
        else if (active_mask[1]) low_idx = 2'd1;
        else if (active_mask[2]) low_idx = 2'd2;
        else if (active_mask[3]) low_idx = 2'd3;
    end

`ifdef MAXNET_TIMEOUT_EN
    assign limit_hit = (iter_count == ITER_W'(MAX_ITER));
`else
    assign limit_hit = 1'b0;
`endif

    always_comb begin
        state_nxt   = state;
        clr_results = 1'b0;
        res_we      = 1'b0;
        set_timeout = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt   = S_LOAD;
                    clr_results = 1'b1;
                end
            end
            S_LOAD:   state_nxt = S_EVAL;
            S_EVAL: begin
                if (converged) begin
                    res_we    = 1'b1;
                    state_nxt = S_DONE;
                end else if (limit_hit) begin
                    res_we      = 1'b1;
                    set_timeout = 1'b1;
                    state_nxt   = S_DONE;
                end else begin
                    state_nxt = S_UPDATE;
                end
            end
            S_UPDATE: state_nxt = S_EVAL;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Strobes decode straight from the state register, so reset clears
    // them immediately and init/write_reg can never overlap.
    assign init      = (state == S_LOAD);
    assign write_reg = (state == S_UPDATE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            winner     <= 2'd0;
            none_left  <= 1'b0;
            iter_count <= '0;
        end else begin
            state <= state_nxt;
            if (clr_results) begin
                winner     <= 2'd0;
                none_left  <= 1'b0;
                iter_count <= '0;
            end else begin
                if (res_we) begin
                    winner    <= low_idx;
                    // A timed-out search always has >= 2 bits set here.
                    none_left <= (active_mask == 4'd0);
                end
                if (state == S_UPDATE && iter_count != {ITER_W{1'b1}})
                    iter_count <= iter_count + ITER_W'(1);
            end
        end
    end

`ifdef MAXNET_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)             timeout <= 1'b0;
        else if (clr_results) timeout <= 1'b0;
        else if (set_timeout) timeout <= 1'b1;
    end
`else
    assign timeout = 1'b0;
    logic unused_set_timeout;
    assign unused_set_timeout = set_timeout;
`endif

endmodule

// File: tb/tb_maxnet_controller.sv
module tb_maxnet_controller;
    localparam int ITER_W = 7;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [3:0]        active_mask;
    logic              init, write_reg, busy, done, none_left, timeout;
    logic [1:0]        winner;
    logic [ITER_W-1:0] iter_count;

    maxnet_controller #(.MAX_ITER(4), .ITER_W(ITER_W)) dut (
        .clk(clk), .rst(rst), .start(start), .active_mask(active_mask),
        .init(init), .write_reg(write_reg), .busy(busy), .done(done),
        .winner(winner), .none_left(none_left), .iter_count(iter_count),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0][3:0] seq;
        int len, e_done, e_win, e_none, e_iter, e_to;
    } vec_t;

    vec_t vt[8];
    int   nv = 0;

    task automatic add_vec(input logic [3:0] s0, s1, s2, input int len,
                           input int e_done, e_win, e_none, e_iter, e_to);
        vt[nv].seq    = {4'h0, s2, s1, s0};
        vt[nv].len    = len;
        vt[nv].e_done = e_done;
        vt[nv].e_win  = e_win;
        vt[nv].e_none = e_none;
        vt[nv].e_iter = e_iter;
        vt[nv].e_to   = e_to;
        nv++;
    endtask

    // Results of the last run_search.
    int   r_done, r_init, r_init_n, r_wr, r_overlap;
    logic [1:0] r_win;
    logic r_none, r_to, r_busy_after, r_done_after, r_win_stable;
    logic [ITER_W-1:0] r_iter;

    // Starts a search and plays the role of the datapath: the mask for each
    // EVAL is applied right after the init/write_reg edge that produced it.
    // Cycle n=1 is the period right after the edge that sampled start.
    task automatic run_search(input logic [3:0][3:0] seq, input int len, input int budget);
        int n, idx;
        logic [3:0] pend;
        r_done = -1; r_init = -1; r_init_n = 0; r_wr = 0; r_overlap = 0;
        active_mask = 4'b1111;
        pend = active_mask;
        idx = 0;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 1;
        while (n <= budget && r_done < 0) begin
            @(negedge clk);
            if (init && write_reg) r_overlap++;
            if (init) begin
                if (r_init < 0) r_init = n;
                r_init_n++;
                pend = seq[0];
                idx = 1;
            end
            if (write_reg) begin
                r_wr++;
                pend = seq[(idx < len) ? idx : len - 1];
                idx++;
            end
            if (done) begin
                r_done = n;
                r_win  = winner;
                r_none = none_left;
                r_to   = timeout;
                r_iter = iter_count;
            end else begin
                @(posedge clk);
                #1 active_mask = pend;
                n++;
            end
        end
        if (r_done >= 0) begin
            @(negedge clk);
            r_busy_after = busy;
            r_done_after = done;
            r_win_stable = (winner == r_win) && (iter_count == r_iter);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int seen, it_before, inits;
        rst = 1'b0;
        start = 1'b0;
        active_mask = 4'b0000;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        chk("rst_init", init, 0);
        chk("rst_write_reg", write_reg, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_winner", winner, 0);
        chk("rst_none_left", none_left, 0);
        chk("rst_iter", iter_count, 0);
        chk("rst_timeout", timeout, 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(posedge clk);

        //         s0       s1       s2      len done win none iter to
        add_vec(4'b0100, 4'b0000, 4'b0000, 1, 3,  2,  0,   0,   0);
        add_vec(4'b1111, 4'b1011, 4'b0010, 3, 7,  1,  0,   2,   0);
        add_vec(4'b0110, 4'b0000, 4'b0000, 2, 5,  0,  1,   1,   0);
        add_vec(4'b1000, 4'b0000, 4'b0000, 1, 3,  3,  0,   0,   0);
        add_vec(4'b0001, 4'b0000, 4'b0000, 1, 3,  0,  0,   0,   0);
        add_vec(4'b0000, 4'b0000, 4'b0000, 1, 3,  0,  1,   0,   0);
        add_vec(4'b1110, 4'b1100, 4'b1000, 3, 7,  3,  0,   2,   0);
`ifdef MAXNET_TIMEOUT_EN
        add_vec(4'b1100, 4'b1100, 4'b1100, 1, 11, 2,  0,   4,   1);
`endif

        for (int i = 0; i < nv; i++) begin
            run_search(vt[i].seq, vt[i].len, 40);
            chk($sformatf("v%0d_done_cycle", i), r_done, vt[i].e_done);
            if (r_done >= 0) begin
                chk($sformatf("v%0d_init_cycle", i), r_init, 1);
                chk($sformatf("v%0d_init_pulses", i), r_init_n, 1);
                chk($sformatf("v%0d_write_reg_pulses", i), r_wr, vt[i].e_iter);
                chk($sformatf("v%0d_iter_count", i), r_iter, vt[i].e_iter);
                chk($sformatf("v%0d_winner", i), r_win, vt[i].e_win);
                chk($sformatf("v%0d_none_left", i), r_none, vt[i].e_none);
                chk($sformatf("v%0d_timeout", i), r_to, vt[i].e_to);
                chk($sformatf("v%0d_strobe_overlap", i), r_overlap, 0);
                chk($sformatf("v%0d_busy_after_done", i), r_busy_after, 0);
                chk($sformatf("v%0d_done_one_cycle", i), r_done_after, 0);
                chk($sformatf("v%0d_results_stable", i), r_win_stable, 1);
            end
        end

        // Reset asserted mid-UPDATE (second update, so iter_count is non-zero).
        active_mask = 4'b1100;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 0; c < 20 && seen == 0; c++) begin
            @(negedge clk);
            if (write_reg && iter_count != 0) seen = 1;
        end
        chk("midrst_reached_update", seen, 1);
        rst = 1'b0;
        #1;
        chk("midrst_write_reg", write_reg, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_iter", iter_count, 0);
        chk("midrst_winner", winner, 0);
        chk("midrst_init", init, 0);
        @(negedge clk) rst = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        chk("midrst_quiet_after", seen, 0);

`ifndef MAXNET_TIMEOUT_EN
        // Stuck mask without the limit: keeps iterating, ignores start,
        // and iter_count saturates instead of wrapping.
        active_mask = 4'b1100;
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        seen = 0;
        for (int c = 2; c <= 50; c++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("stuck_busy_k50", busy, 1);
        chk("stuck_timeout_k50", timeout, 0);
        chk("stuck_no_done", seen, 0);
        it_before = int'(iter_count);
        @(negedge clk) start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        chk("stuck_start_ignored", int'(iter_count) >= it_before, 1);
        inits = 0;
        for (int c = 0; c < 270; c++) begin
            @(negedge clk);
            if (init) inits++;
            if (done) seen++;
        end
        chk("stuck_no_reload", inits, 0);
        chk("stuck_still_no_done", seen, 0);
        chk("stuck_iter_saturated", iter_count, 127);
        active_mask = 4'b0010;
        seen = 0;
        for (int c = 0; c < 6 && seen == 0; c++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        chk("stuck_converges", seen, 1);
        chk("stuck_winner", winner, 1);
        chk("stuck_iter_final", iter_count, 127);
        chk("stuck_timeout_final", timeout, 0);
        chk("stuck_none_left", none_left, 0);
`endif

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
